counter_loadable_bank: RTL
==========================

# counter_loadable_bank

Bank of `CH` independent loadable up-counters sharing one register-write port. Each channel has its own reload value, terminal value, enable and auto-reload mode. Each channel flags terminal count as a level (`DONE`) and as a one-cycle event (`PULSE`). It is the multi-channel, reloadable successor of the single loadable counter, and serves as the timer/event-count resource for ring-node control logic.

## Interface
Parameters:
- `N`, 8: counter width in bits.
- `CH`, 4: number of channels.
- `SEL_W`, 2: width of the channel select. Must satisfy 2^`SEL_W` >= `CH`.
- `STEP`, 1: unsigned increment per advance, 1 to 2^`N`-1.
- `PRESCALE`, 4: tick divider. Present only with `CNT_PRESCALE_EN`. Must be >= 1.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `WR`  in  1  register write strobe.
- `WSEL`  in  `SEL_W`  target channel. Writes with `WSEL` >= `CH` are ignored.
- `WREG`  in  1  write target: 0 = load COUNT and RELOAD together; 1 = load TERM.
- `DIN`  in  `N`  write data.
- `EN`  in  `CH`  per-channel count enable.
- `AUTO`  in  `CH`  per-channel auto-reload mode. 1 = reload at terminal; 0 = stop at terminal.
- `COUNT`  out  `CH`*`N`  flattened counts; channel i occupies bits [i*N +: N].
- `DONE`  out  `CH`  level flag: COUNT[i] == TERM[i] (combinational compare of registers).
- `PULSE`  out  `CH`  registered one-cycle terminal event.

## Operation
- Per-channel state: COUNT, RELOAD and TERM (each `N` bits), plus the PULSE flop.
- Reset (`RST_N`=0, asynchronous) sets:
  - COUNT = 0
  - RELOAD = 0
  - TERM = all ones
  - PULSE = 0
  - prescaler = 0

  After reset, DONE = 0.
- Tick: 1 every cycle without the macro. With the macro, see Configuration.
- Per-channel priority each edge, highest first:
  1. Write hit (`WR` && `WSEL`==i):
     - `WREG`=0: COUNT <= DIN and RELOAD <= DIN.
     - `WREG`=1: TERM <= DIN.
     - PULSE <= 0. `EN` and tick are ignored for that channel this cycle.
  2. `EN[i]` && tick && COUNT==TERM:
     - `AUTO`=1: COUNT <= RELOAD, PULSE <= 0.
     - `AUTO`=0: COUNT holds (stopped), PULSE <= 0.
  3. `EN[i]` && tick: COUNT <= COUNT + `STEP`, modulo 2^`N`. PULSE <= 1 iff (COUNT + `STEP`) mod 2^`N` == TERM.
  4. Otherwise: COUNT holds, PULSE <= 0.
- A stopped channel (`AUTO`=0 at terminal) restarts only after a `WREG`=0 write, or after a TERM write that moves TERM away from COUNT.
- Equality-only match: with `STEP` > 1 the count can jump past TERM. In that case the channel wraps modulo 2^`N` and no PULSE is produced until a later exact hit.
- A write that makes COUNT == TERM raises DONE but never PULSE.
- Toggling `AUTO` takes effect on the next terminal evaluation. Channels never interact.

## Timing
- Write latency: 1 edge. The new COUNT and TERM are visible, and DONE re-evaluates, in the cycle after `WR`.
- Count latency: COUNT updates on the edge where `EN`&&tick is sampled.
- PULSE rises in the same cycle as the DONE rising edge caused by counting. It lasts exactly 1 cycle.
- Auto-reload: the edge after reaching terminal loads RELOAD. In that cycle DONE falls, unless RELOAD == TERM.
- Reset deassertion is synchronous to operation: the first counting edge is the first rising `CLK` with `RST_N`=1.
- Reset asserted mid-count forces every output to its reset value immediately, without waiting for `CLK`.

## Configuration
- Macro: `CNT_PRESCALE_EN`.
- Defined:
  - A shared free-running prescaler counts 0..`PRESCALE`-1 and wraps.
  - Tick = 1 only in the cycle the prescaler equals `PRESCALE`-1, so channels advance once per `PRESCALE` cycles.
  - Writes are not prescaled.
  - `PRESCALE`=1 behaves identically to undefined.
- Undefined: no prescaler logic and no `PRESCALE` parameter; tick is constant 1.

## Test plan
- Reset and defaults: hold `RST_N`=0 for 3 cycles, then release with `EN`=0.
  - Required: all COUNT=0, DONE=0, PULSE=0.
  - Next: write TERM=0 on channel 2. Required: DONE[2]=1 next cycle, PULSE[2]=0.
- Auto-reload, N=8, STEP=1, channel 0: write RELOAD/COUNT=250, TERM=253, then `AUTO`=1, `EN`=1.
  - Required: COUNT 251, 252, 253 (DONE=PULSE=1), 250, 251, … with a PULSE every 4 cycles.
- Stop mode, channel 1: COUNT=5, TERM=7, `AUTO`=0, `EN`=1.
  - Required: COUNT reaches 7, PULSE is 1 for one cycle, then COUNT holds at 7 with DONE=1 for 10+ cycles.
  - Next: write TERM=9. Required: counting resumes to 9.
- Wrap and skip, STEP=3: COUNT=254, TERM=0.
  - Required: next COUNT=1 (wrap, no PULSE, no DONE).
- Write-versus-count collision: channel 3 with `EN`=1 at COUNT=10, write DIN=100 (`WREG`=0) in the same cycle.
  - Required: COUNT=100 next cycle, not 11.
  - Meanwhile, other channels keep counting unaffected.
- Prescale (macro defined, `PRESCALE`=4): `EN`=1 from COUNT=0.
  - Required: COUNT increments once every 4 cycles.
  - Then assert `RST_N`=0 mid-count. Required: COUNT=0 asynchronously, and the prescaler restarts at 0.

Source files
------------

// File: rtl/counter_loadable_bank.sv
// counter_loadable_bank: CH-channel loadable up-counter bank with reload, terminal match, DONE level and one-cycle PULSE.
// Optional shared tick prescaler is enabled by defining CNT_PRESCALE_EN (adds the PRESCALE parameter).
module counter_loadable_bank #(
  parameter int N = 8,
  parameter int CH = 4,
  parameter int SEL_W = 2,
  parameter int STEP = 1
`ifdef CNT_PRESCALE_EN
  , parameter int PRESCALE = 4
`endif
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            wr_i,
  input  logic [SEL_W-1:0] wsel_i,
  input  logic            wreg_i,
  input  logic [N-1:0]    din_i,
  input  logic [CH-1:0]   en_i,
  input  logic [CH-1:0]   auto_i,
  output logic [CH*N-1:0] count_o,
  output logic [CH-1:0]   done_o,
  output logic [CH-1:0]   pulse_o
);
  logic tick;
`ifdef CNT_PRESCALE_EN
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;
  assign tick = pre_q == PW'(PRESCALE - 1);
  assign pre_d = tick ? '0 : pre_q + 1'b1;
  // Shared free-running divider; tick fires on its last count.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) pre_q <= '0;
    else pre_q <= pre_d;
`else
  assign tick = 1'b1;
`endif
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [N-1:0] cnt_q, cnt_d, rld_q, rld_d, trm_q, trm_d, nxt;
    logic hit, run, done, pls_q, pls_d;
    assign hit = wr_i && wsel_i == SEL_W'(i);
    assign run = en_i[i] && tick;
    assign done = cnt_q == trm_q;
    assign nxt = cnt_q + N'(STEP);
    assign count_o[i*N +: N] = cnt_q;
    assign done_o[i] = done;
    assign pulse_o[i] = pls_q;
    // Write beats terminal handling, which beats plain counting; a stopped channel just holds.
    always_comb begin
      cnt_d = hit ? (wreg_i ? cnt_q : din_i) : (run && !done) ? nxt : (run && auto_i[i]) ? rld_q : cnt_q;
      rld_d = (hit && !wreg_i) ? din_i : rld_q;
      trm_d = (hit && wreg_i) ? din_i : trm_q;
      pls_d = !hit && run && !done && nxt == trm_q;
    end
    // Channel registers; TERM resets to all ones so DONE starts low.
    always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
        cnt_q <= '0;
        rld_q <= '0;
        trm_q <= '1;
        pls_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        rld_q <= rld_d;
        trm_q <= trm_d;
        pls_q <= pls_d;
      end
  end
endmodule
